updw_mon: RTL
=============

// Module: updw_mon
// PURPOSE
//  Receive-side monitor for the up/down counter's o_cnt stream. Samples the count each
//  valid cycle, classifies every step (up, down, hold, illegal) and infers the counter's
//  mode from it. Reports direction lock, wrap events and illegal steps, and keeps a
//  saturating error count. Sits beside the counter in benches and in debug logic.
// PARAMETERS
//  UPBND  11  counter upper bound; legal values 0..UPBND, requires UPBND>=2
//  LOCK   3   consecutive same-direction steps needed to lock direction, >=1
//  ERRW   8   width of the error counter
// PORTS
//  i_clk      in   1                      clock, all logic on rising edge
//  i_rstn     in   1                      asynchronous, active-low reset
//  i_cnt      in   $clog2(UPBND+1)        observed count value
//  i_vld      in   1                      i_cnt valid this cycle (sample strobe)
//  i_clr      in   1                      sync clear of state and error count
//  o_mode     out  1                      inferred direction, 1=up 0=down; valid while locked
//  o_lock     out  1                      direction locked
//  o_wrap     out  1                      1-cycle pulse: legal wrap step seen
//  o_err      out  1                      1-cycle pulse: illegal step or out-of-range sample
//  o_err_cnt  out  ERRW                   saturating count of o_err pulses
// BEHAVIOUR
//  Reset: state=IDLE, o_mode=1, o_lock=0, o_wrap=0, o_err=0, o_err_cnt=0; the assertion is asynchronous.
//  All outputs are registered. Latency: the response to a sample at edge N appears after edge N.
//  Step classification (prev -> cur, only when i_vld=1 and prev is held):
//   UP    cur==prev+1, or prev==UPBND && cur==0 (wrap)
//   DN    cur==prev-1, or prev==0 && cur==UPBND (wrap)
//   HOLD  cur==prev
//   BAD   anything else
//   RANGE cur>UPBND; this overrides all classes.
//  FSM states: IDLE (no prev), ACQ (prev held, run/dir counting), LOCKD.
//   IDLE: on i_vld with cur in range, store prev, set run=0, go to ACQ.
//         On RANGE, pulse o_err and stay in IDLE.
//   ACQ: on UP/DN in the same dir as run (or run==0), set run+1 and dir=step.
//        On the opposite dir, set run=1 and dir=step. When run reaches LOCK, go to LOCKD,
//        set o_lock=1, o_mode=dir. On HOLD, no change. On BAD, pulse o_err and set run=0.
//   LOCKD: on a step in dir, no change. On the opposite step (mode switch, legal),
//          set o_lock=0, run=1, dir=step, and go to ACQ; o_mode keeps its old value until relock.
//          On BAD, pulse o_err, set o_lock=0, run=0, and go to ACQ.
//   Any state on RANGE: pulse o_err, set o_lock=0, drop prev, and go to IDLE.
//   Every accepted in-range sample updates prev.
//  o_wrap pulses on a wrap-class UP/DN step in any state (ACQ or LOCKD), independent of lock.
//  o_err_cnt increments with each o_err pulse and saturates at 2^ERRW-1; it never wraps.
//  i_vld=0: state, prev and run hold; o_wrap and o_err return to 0.
//  i_clr=1 has priority over i_vld. It forces IDLE, o_lock=0, o_err_cnt=0, and no pulses;
//   o_mode holds.
//  LOCK==1: the first UP/DN step locks immediately.
//  Reset asserted mid-operation returns all state and outputs to reset values at once.
// TESTING  (UPBND=11, LOCK=3, ERRW=8 unless noted)
//  1. Reset, then i_vld=1 with i_cnt 0,1,2,3 -> o_lock=1 and o_mode=1 after the edge
//     sampling 3; o_err is never asserted.
//  2. Locked up, i_cnt 10,11,0,1 -> single o_wrap pulse after the edge sampling 0;
//     o_lock stays 1.
//  3. Locked up, i_cnt 5,4,3,2 -> o_lock=0 after 4 (o_mode still 1); o_lock=1 and o_mode=0
//     after 2. Then 1,0,11 -> o_wrap after 11.
//  4. Locked, i_cnt 3 then 7 -> o_err pulse, o_err_cnt=1, o_lock=0. Then i_cnt 12 ->
//     o_err pulse, o_err_cnt=2, state IDLE.
//  5. ERRW=2, five RANGE samples -> o_err_cnt 1,2,3,3,3. Then i_clr with i_vld=1 ->
//     o_err_cnt=0, IDLE, no pulse.
//  6. Locked, i_vld gaps and HOLD samples (4,4,_,5) -> no err and lock kept. Then i_rstn=0
//     mid-stream -> all outputs reset immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/updw_mon.sv
// ---------------------------------------------------------------------------
// updw_mon : receive-side monitor for an up/down counter's count stream.
// Classifies every sampled step (up, down, hold, illegal), infers the counting
// direction, reports direction lock, wrap steps and illegal steps, and keeps a
// saturating error count. All outputs are registered.
//
// Ports
//   i_clk      clock, rising edge
//   i_rstn     asynchronous active-low reset
//   i_cnt      observed count value
//   i_vld      i_cnt valid this cycle
//   i_clr      synchronous clear of state and error count (beats i_vld)
//   o_mode     inferred direction, 1=up 0=down; meaningful while o_lock=1
//   o_lock     direction locked
//   o_wrap     one-cycle pulse on a legal wrap step
//   o_err      one-cycle pulse on an illegal step or out-of-range sample
//   o_err_cnt  saturating count of o_err pulses
// ---------------------------------------------------------------------------
module updw_mon #(
    parameter int unsigned UPBND = 11,
    parameter int unsigned LOCK  = 3,
    parameter int unsigned ERRW  = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rstn,
    input  logic [$clog2(UPBND+1)-1:0]   i_cnt,
    input  logic                         i_vld,
    input  logic                         i_clr,
    output logic                         o_mode,
    output logic                         o_lock,
    output logic                         o_wrap,
    output logic                         o_err,
    output logic [ERRW-1:0]              o_err_cnt
);

    localparam int unsigned CW = $clog2(UPBND + 1);
    localparam int unsigned RW = $clog2(LOCK + 1);
    localparam logic [CW-1:0] TOP = CW'(UPBND);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACQ   = 2'd1,
        S_LOCKD = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   prev_q, prev_d;
    logic [RW-1:0]   run_q, run_d;
    logic            dir_q, dir_d;
    logic            mode_d, lock_d, wrap_d, err_d;
    logic [ERRW-1:0] err_cnt_d;

    // Step classification of the current sample against the held previous one
    logic in_rng, up_lin, up_wrap, dn_lin, dn_wrap, step_up, step_dn, step_hold, step_bad;
    logic [RW-1:0] run_inc;

    assign in_rng    = (i_cnt <= TOP);
    assign up_lin    = (prev_q != TOP)     && (i_cnt == prev_q + CW'(1));
    assign up_wrap   = (prev_q == TOP)     && (i_cnt == '0);
    assign dn_lin    = (prev_q != '0)      && (i_cnt == prev_q - CW'(1));
    assign dn_wrap   = (prev_q == '0)      && (i_cnt == TOP);
    assign step_up   = up_lin | up_wrap;
    assign step_dn   = dn_lin | dn_wrap;
    assign step_hold = (i_cnt == prev_q);
    assign step_bad  = !(step_up || step_dn || step_hold);
    // run never exceeds LOCK outside LOCKD, so the increment cannot overflow
    assign run_inc   = run_q + RW'(1);

    // State and registered outputs
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= S_IDLE;
            prev_q    <= '0;
            run_q     <= '0;
            dir_q     <= 1'b1;
            o_mode    <= 1'b1;
            o_lock    <= 1'b0;
            o_wrap    <= 1'b0;
            o_err     <= 1'b0;
            o_err_cnt <= '0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            run_q     <= run_d;
            dir_q     <= dir_d;
            o_mode    <= mode_d;
            o_lock    <= lock_d;
            o_wrap    <= wrap_d;
            o_err     <= err_d;
            o_err_cnt <= err_cnt_d;
        end
    end

    // Next-state: FSM state, previous sample, run length and step direction
    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        run_d   = run_q;
        dir_d   = dir_q;
        if (i_clr) begin
            state_d = S_IDLE;
            run_d   = '0;
        end else if (i_vld) begin
            if (!in_rng) begin
                state_d = S_IDLE;
                run_d   = '0;
            end else begin
                prev_d = i_cnt;
                unique case (state_q)
                    S_IDLE: begin
                        run_d   = '0;
                        state_d = S_ACQ;
                    end
                    S_ACQ: begin
                        if (step_up || step_dn) begin
                            dir_d = step_up;
                            // a direction change restarts the run at one step
                            if (run_q == '0 || dir_q == step_up) begin
                                run_d = run_inc;
                                if (run_inc >= RW'(LOCK)) state_d = S_LOCKD;
                            end else begin
                                run_d = RW'(1);
                                if (RW'(1) >= RW'(LOCK)) state_d = S_LOCKD;
                            end
                        end else if (step_bad) begin
                            run_d = '0;
                        end
                    end
                    S_LOCKD: begin
                        if ((step_up || step_dn) && (step_up != dir_q)) begin
                            // legal mode switch: reacquire, unless one step already locks
                            dir_d = step_up;
                            run_d = RW'(1);
                            if (RW'(1) < RW'(LOCK)) state_d = S_ACQ;
                        end else if (step_bad) begin
                            run_d   = '0;
                            state_d = S_ACQ;
                        end
                    end
                    default: begin
                        state_d = S_IDLE;
                        run_d   = '0;
                    end
                endcase
            end
        end
    end

    // Output values for the next edge
    always_comb begin
        lock_d    = (state_d == S_LOCKD);
        // o_mode follows the locked direction and freezes while unlocked
        mode_d    = lock_d ? dir_d : o_mode;
        wrap_d    = 1'b0;
        err_d     = 1'b0;
        err_cnt_d = o_err_cnt;
        if (i_clr) begin
            err_cnt_d = '0;
        end else if (i_vld) begin
            if (!in_rng) begin
                err_d = 1'b1;
            end else if (state_q != S_IDLE) begin
                wrap_d = up_wrap | dn_wrap;
                err_d  = step_bad;
            end
            if (err_d && !(&o_err_cnt)) err_cnt_d = o_err_cnt + ERRW'(1);
        end
    end

endmodule
